// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
// ram_arbiter_pkg : shared state encoding and port indices for ram_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_rr_select2.sv
// ============================================================================
// rr_select2 : combinational two-way round-robin picker with priority override
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_select2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       force_en_i,
    input  logic       force_idx_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (force_en_i) begin
            gnt_o[force_idx_i] = 1'b1;
        end else if (req_i == 2'b11) begin
            // Tie: the port that did not win last time goes now.
            gnt_o = last_i ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// ram_arbiter : shares the single-port data RAM between CPU MEM stage and
//               loader with round-robin arbitration and bounded burst lock
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int RAM_ADDR_W = 16,
    parameter int DATA_W     = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic                  m0_lock,
    input  logic [RAM_ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [RAM_ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [RAM_ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0]     ram_write_data,
    output logic                  ram_wren,
    input  logic [DATA_W-1:0]     ram_data
);

    localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

    arb_state_e            state_q;
    logic                  last_gnt_q;
    logic [3:0]            burst_cnt_q;
    logic [3:0]            burst_cnt_d;
    logic                  rd_pend_q;
    logic                  rd_owner_q;
    logic [RAM_ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;

    logic                  lock_st_w;
    logic                  lock_idx_w;
    logic                  owner_req_w;
    logic                  other_req_w;
    logic                  force_en_w;
    logic [1:0]            sel_gnt_w;
    logic [1:0]            gnt_w;
    logic                  any_gnt_w;
    logic                  win_idx_w;
    logic                  win_we_w;
    logic                  win_lock_w;
    logic [RAM_ADDR_W-1:0] win_addr_w;
    logic [DATA_W-1:0]     win_wdata_w;

    assign lock_st_w   = (state_q != IDLE);
    assign lock_idx_w  = (state_q == LOCK1);
    assign owner_req_w = lock_idx_w ? m1_req : m0_req;
    assign other_req_w = lock_idx_w ? m0_req : m1_req;

    // The lock owner keeps priority until saturated, and even past that
    // while the other port stays quiet.
    assign force_en_w  = lock_st_w && owner_req_w &&
                         ((burst_cnt_q < MAX_BURST_C) || !other_req_w);

    rr_select2 u_rr_select2 (
        .req_i       ({m1_req, m0_req}),
        .last_i      (last_gnt_q),
        .force_en_i  (force_en_w),
        .force_idx_i (lock_idx_w),
        .gnt_o       (sel_gnt_w)
    );

    assign gnt_w       = reset_n ? sel_gnt_w : 2'b00;
    assign any_gnt_w   = |gnt_w;
    assign win_idx_w   = gnt_w[PORT_LOADER];
    assign win_we_w    = win_idx_w ? m1_we    : m0_we;
    assign win_lock_w  = win_idx_w ? m1_lock  : m0_lock;
    assign win_addr_w  = win_idx_w ? m1_addr  : m0_addr;
    assign win_wdata_w = win_idx_w ? m1_wdata : m0_wdata;

    assign m0_gnt         = gnt_w[PORT_CPU];
    assign m1_gnt         = gnt_w[PORT_LOADER];
    assign ram_wren       = any_gnt_w & win_we_w;
    assign ram_address    = any_gnt_w ? win_addr_w  : addr_q;
    assign ram_write_data = any_gnt_w ? win_wdata_w : wdata_q;

    assign m0_rvalid = reset_n & rd_pend_q & (rd_owner_q == PORT_CPU);
    assign m1_rvalid = reset_n & rd_pend_q & (rd_owner_q == PORT_LOADER);
    assign m0_rdata  = m0_rvalid ? ram_data : '0;
    assign m1_rdata  = m1_rvalid ? ram_data : '0;

    assign burst_cnt_d = (burst_cnt_q < MAX_BURST_C) ? burst_cnt_q + 4'd1 : burst_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            burst_cnt_q <= 4'd0;
            rd_pend_q   <= 1'b0;
            rd_owner_q  <= PORT_CPU;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            rd_pend_q <= any_gnt_w & ~win_we_w;
            if (any_gnt_w) begin
                rd_owner_q <= win_idx_w;
                last_gnt_q <= win_idx_w;
                addr_q     <= win_addr_w;
                wdata_q    <= win_wdata_w;
            end
            unique case (state_q)
                IDLE: begin
                    if (any_gnt_w && win_lock_w) begin
                        state_q     <= win_idx_w ? LOCK1 : LOCK0;
                        burst_cnt_q <= 4'd1;
                    end else begin
                        burst_cnt_q <= 4'd0;
                    end
                end
                LOCK0, LOCK1: begin
                    if (any_gnt_w && (win_idx_w == lock_idx_w) && win_lock_w) begin
                        burst_cnt_q <= burst_cnt_d;
                    end else begin
                        state_q     <= IDLE;
                        burst_cnt_q <= 4'd0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    burst_cnt_q <= 4'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// tb_ram_arbiter : directed self-checking bench for ram_arbiter with RAM model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

    logic        clk;
    logic        reset_n;
    logic        m0_req, m0_we, m0_lock;
    logic [15:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we, m1_lock;
    logic [15:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic [15:0] ram_address;
    logic [31:0] ram_write_data;
    logic        ram_wren;
    logic [31:0] ram_data;

    logic [31:0] mem [0:255];
    logic        mem_init;
    int          n_vec;
    int          n_err;

    ram_arbiter u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0_req         (m0_req),
        .m0_we          (m0_we),
        .m0_lock        (m0_lock),
        .m0_addr        (m0_addr),
        .m0_wdata       (m0_wdata),
        .m0_gnt         (m0_gnt),
        .m0_rvalid      (m0_rvalid),
        .m0_rdata       (m0_rdata),
        .m1_req         (m1_req),
        .m1_we          (m1_we),
        .m1_lock        (m1_lock),
        .m1_addr        (m1_addr),
        .m1_wdata       (m1_wdata),
        .m1_gnt         (m1_gnt),
        .m1_rvalid      (m1_rvalid),
        .m1_rdata       (m1_rdata),
        .ram_address    (ram_address),
        .ram_write_data (ram_write_data),
        .ram_wren       (ram_wren),
        .ram_data       (ram_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with one cycle of read latency; preset to A000_0000+addr.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else if (ram_wren) begin
            mem[ram_address[7:0]] <= ram_write_data;
        end
        ram_data <= mem[ram_address[7:0]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic req, input logic we, input logic lock,
                          input logic [15:0] addr, input logic [31:0] wd);
        m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = wd;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic lock,
                          input logic [15:0] addr, input logic [31:0] wd);
        m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wd;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        mem_init = 1'b1;
        set_m1(0, 0, 0, 16'h0, 32'h0);
        set_m0(1, 1, 0, 16'h0010, 32'hDEAD_BEEF);
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        #1;
        check("rst_m0_gnt",   m0_gnt,    1'b0);
        check("rst_m1_gnt",   m1_gnt,    1'b0);
        check("rst_wren",     ram_wren,  1'b0);
        check("rst_m0_rvalid", m0_rvalid, 1'b0);
        check("rst_m0_rdata", m0_rdata,  32'h0);

        // Single CPU read
        @(negedge clk); reset_n = 1'b1; set_m0(1, 0, 0, 16'h0010, 32'h0); #1;
        check("rd_m0_gnt",  m0_gnt,      1'b1);
        check("rd_m1_gnt",  m1_gnt,      1'b0);
        check("rd_addr",    ram_address, 16'h0010);
        check("rd_wren",    ram_wren,    1'b0);
        @(negedge clk); set_m0(0, 0, 0, 16'h0, 32'h0); #1;
        check("rd_m0_rvalid", m0_rvalid,   1'b1);
        check("rd_m0_rdata",  m0_rdata,    32'hA000_0010);
        check("rd_m1_rvalid", m1_rvalid,   1'b0);
        check("rd_m1_rdata",  m1_rdata,    32'h0);
        check("hold_addr",    ram_address, 16'h0010);
        check("idle_gnt",     m0_gnt,      1'b0);

        // Loader write alone
        @(negedge clk); set_m1(1, 1, 0, 16'h0020, 32'h1111_2222); #1;
        check("wr_m1_gnt",  m1_gnt,         1'b1);
        check("wr_wren",    ram_wren,       1'b1);
        check("wr_wdata",   ram_write_data, 32'h1111_2222);

        // Contending writes, no lock: grants alternate
        @(negedge clk);
        set_m0(1, 1, 0, 16'h0030, 32'h0000_00D0);
        set_m1(1, 1, 0, 16'h0040, 32'h0000_00E0);
        #1;
        check("alt1_m0", m0_gnt, 1'b1);
        check("alt1_m1", m1_gnt, 1'b0);
        @(negedge clk); set_m0(1, 1, 0, 16'h0031, 32'h0000_00D1); #1;
        check("alt2_m1", m1_gnt, 1'b1);
        check("alt2_m0", m0_gnt, 1'b0);
        @(negedge clk); set_m1(1, 1, 1, 16'h0041, 32'h0000_00E1); #1;
        check("alt3_m0", m0_gnt, 1'b1);
        check("alt3_m1", m1_gnt, 1'b0);

        // Loader burst with lock against a waiting CPU read
        @(negedge clk); set_m0(1, 0, 0, 16'h0050, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            #1;
            check($sformatf("burst%0d_m1", k), m1_gnt, (k <= 4));
            check($sformatf("burst%0d_m0", k), m0_gnt, (k == 5));
            @(negedge clk);
            if (k <= 4) set_m1(1, 1, 1, 16'h0041 + 16'(k), 32'h0000_00E1 + 32'(k));
            else        set_m0(0, 0, 0, 16'h0, 32'h0);
        end
        #1;
        check("burst_m0_rvalid", m0_rvalid, 1'b1);
        check("burst_m0_rdata",  m0_rdata,  32'hA000_0050);
        check("burst_m1_rvalid", m1_rvalid, 1'b0);
        check("burst_m1_resume", m1_gnt,    1'b1);
        @(negedge clk); set_m1(0, 0, 0, 16'h0, 32'h0); #1;
        check("mem_20", mem[8'h20], 32'h1111_2222);
        check("mem_30", mem[8'h30], 32'h0000_00D0);
        check("mem_31", mem[8'h31], 32'h0000_00D1);
        check("mem_40", mem[8'h40], 32'h0000_00E0);
        check("mem_41", mem[8'h41], 32'h0000_00E1);
        check("mem_44", mem[8'h44], 32'h0000_00E4);
        check("mem_45", mem[8'h45], 32'h0000_00E5);

        // Alternating reads route data to the issuer only
        @(negedge clk); set_m0(1, 0, 0, 16'h0004, 32'h0); #1;
        check("ar1_m0_gnt", m0_gnt, 1'b1);
        @(negedge clk); set_m0(0, 0, 0, 16'h0, 32'h0); set_m1(1, 0, 0, 16'h0008, 32'h0); #1;
        check("ar2_m1_gnt",    m1_gnt,    1'b1);
        check("ar2_m0_rvalid", m0_rvalid, 1'b1);
        check("ar2_m0_rdata",  m0_rdata,  32'hA000_0004);
        check("ar2_m1_rvalid", m1_rvalid, 1'b0);
        @(negedge clk); set_m1(0, 0, 0, 16'h0, 32'h0); set_m0(1, 0, 0, 16'h000C, 32'h0); #1;
        check("ar3_m0_gnt",    m0_gnt,    1'b1);
        check("ar3_m1_rvalid", m1_rvalid, 1'b1);
        check("ar3_m1_rdata",  m1_rdata,  32'hA000_0008);
        check("ar3_m0_rvalid", m0_rvalid, 1'b0);
        check("ar3_m0_rdata",  m0_rdata,  32'h0);
        @(negedge clk); set_m0(0, 0, 0, 16'h0, 32'h0); #1;
        check("ar4_m0_rdata",  m0_rdata,  32'hA000_000C);
        check("ar4_m1_rdata",  m1_rdata,  32'h0);

        // Reset right after a granted read
        @(negedge clk); set_m0(1, 0, 0, 16'h0010, 32'h0); #1;
        check("rr_m0_gnt", m0_gnt, 1'b1);
        @(negedge clk); reset_n = 1'b0; set_m0(1, 1, 0, 16'h0070, 32'h7777_7777); #1;
        check("rr_m0_rvalid", m0_rvalid, 1'b0);
        check("rr_wren",      ram_wren,  1'b0);
        check("rr_m0_gnt0",   m0_gnt,    1'b0);
        @(negedge clk); reset_n = 1'b1;
        set_m0(1, 0, 0, 16'h0011, 32'h0);
        set_m1(1, 0, 0, 16'h0012, 32'h0);
        #1;
        check("rr_tie_m0", m0_gnt, 1'b1);
        check("rr_tie_m1", m1_gnt, 1'b0);
        check("rr_mem_70", mem[8'h70], 32'hA000_0070);
        @(negedge clk); set_m0(0, 0, 0, 16'h0, 32'h0); #1;
        check("rr_m1_gnt",   m1_gnt,   1'b1);
        check("rr_m0_rdata", m0_rdata, 32'hA000_0011);

        // Lock released when the owner drops its request
        @(negedge clk);
        set_m1(1, 0, 0, 16'h0061, 32'h0);
        set_m0(1, 1, 1, 16'h0060, 32'h0000_6060);
        #1;
        check("lk_m0_gnt", m0_gnt,   1'b1);
        check("lk_wren",   ram_wren, 1'b1);
        @(negedge clk); set_m0(0, 0, 0, 16'h0, 32'h0); #1;
        check("lk_m1_gnt", m1_gnt, 1'b1);
        check("lk_m0_gnt0", m0_gnt, 1'b0);
        @(negedge clk); set_m1(0, 0, 0, 16'h0, 32'h0); #1;
        check("lk_m1_rvalid", m1_rvalid, 1'b1);
        check("lk_m1_rdata",  m1_rdata,  32'hA000_0061);
        check("lk_mem_60",    mem[8'h60], 32'h0000_6060);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
